// File: rtl/pong_pkg.sv
// pong_pkg: shared state encoding and field widths for the pong game controller and engine.
package pong_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_MISS  = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    localparam int BCD_DIGIT_W = 4;
    localparam int BCD_DIGITS  = 3;
    localparam int SCORE_W     = BCD_DIGIT_W * BCD_DIGITS;
    localparam int LEVEL_W     = 3;
    localparam int LIVES_W     = 2;
    localparam int FRAME_W     = 8;
    localparam int HIT_W       = 4;
    localparam int FLASH_W     = 7;

endpackage

// File: rtl/bcd_score_counter.sv
// bcd_score_counter: multi-digit BCD incrementer that saturates at all nines.
module bcd_score_counter
    import pong_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               inc,
    output logic [SCORE_W-1:0] bcd
);

    logic [SCORE_W-1:0] bcd_n;
    logic               all_nine;
    logic               carry;

    always_comb begin
        all_nine = 1'b1;
        for (int i = 0; i < BCD_DIGITS; i++)
            all_nine = all_nine & (bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W] == BCD_DIGIT_W'(9));
        bcd_n = bcd;
        carry = inc & ~all_nine;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (carry) begin
                if (bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W] == BCD_DIGIT_W'(9)) begin
                    bcd_n[i*BCD_DIGIT_W +: BCD_DIGIT_W] = '0;
                end else begin
                    bcd_n[i*BCD_DIGIT_W +: BCD_DIGIT_W] = bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W] + BCD_DIGIT_W'(1);
                    carry = 1'b0;
                end
            end
        end
        if (clear)
            bcd_n = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            bcd <= '0;
        else
            bcd <= bcd_n;
    end

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: pong phase sequencer (attract/serve/play/miss/over) with score, lives and level keeping.
module game_sequencer
    import pong_pkg::*;
#(
    parameter int unsigned LIVES_INIT     = 3,
    parameter int unsigned SERVE_FRAMES   = 60,
    parameter int unsigned MISS_FRAMES    = 90,
    parameter int unsigned HITS_PER_LEVEL = 5,
    parameter int unsigned MAX_LEVEL      = 7,
    parameter int unsigned FLASH_DIV      = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               start_btn,
    input  logic               hit,
    input  logic               miss,
    output logic               engine_reset,
    output logic               engine_run,
    output logic [LEVEL_W-1:0] level,
    output logic [LIVES_W-1:0] lives,
    output logic [SCORE_W-1:0] score_bcd,
    output logic               flash,
    output logic [2:0]         game_state
);

    state_t             state_q, state_n;
    logic               start_q;
    logic               start_press;
    logic [FRAME_W-1:0] frame_cnt, frame_n;
    logic [HIT_W-1:0]   hit_cnt, hit_n;
    logic [FLASH_W-1:0] flash_cnt, flash_cnt_n;
    logic [LEVEL_W-1:0] level_n;
    logic [LIVES_W-1:0] lives_n;
    logic               flash_n, flash_tog;
    logic               score_clear, score_inc;

    always_comb begin
        start_press = start_btn & ~start_q;
        state_n     = state_q;
        frame_n     = frame_cnt;
        hit_n       = hit_cnt;
        flash_cnt_n = flash_cnt;
        level_n     = level;
        lives_n     = lives;
        flash_tog   = 1'b0;
        score_clear = 1'b0;
        score_inc   = 1'b0;
        case (state_q)
            S_IDLE, S_OVER: begin
                if (start_press) begin
                    state_n     = S_SERVE;
                    frame_n     = FRAME_W'(SERVE_FRAMES);
                    hit_n       = '0;
                    level_n     = '0;
                    lives_n     = LIVES_W'(LIVES_INIT);
                    score_clear = 1'b1;
                end
            end
            S_SERVE: begin
                if (frame_tick) begin
                    frame_n = frame_cnt - FRAME_W'(1);
                    state_n = (frame_cnt == FRAME_W'(1)) ? S_PLAY : S_SERVE;
                end
            end
            S_PLAY: begin
                // a miss in the same cycle as a hit discards the hit
                if (miss) begin
                    lives_n     = lives - LIVES_W'(1);
                    frame_n     = FRAME_W'(MISS_FRAMES);
                    flash_cnt_n = '0;
                    state_n     = (lives > LIVES_W'(1)) ? S_MISS : S_OVER;
                end else if (hit) begin
                    score_inc = 1'b1;
                    if (hit_cnt == HIT_W'(HITS_PER_LEVEL - 1)) begin
                        hit_n   = '0;
                        level_n = (level == LEVEL_W'(MAX_LEVEL)) ? level : level + LEVEL_W'(1);
                    end else begin
                        hit_n = hit_cnt + HIT_W'(1);
                    end
                end
            end
            S_MISS: begin
                if (frame_tick) begin
                    flash_cnt_n = flash_cnt + FLASH_W'(1);
                    flash_tog   = (flash_cnt_n & FLASH_W'(FLASH_DIV - 1)) == '0;
                    frame_n     = (frame_cnt == FRAME_W'(1)) ? FRAME_W'(SERVE_FRAMES) : frame_cnt - FRAME_W'(1);
                    state_n     = (frame_cnt == FRAME_W'(1)) ? S_SERVE : S_MISS;
                end
            end
            default: state_n = S_IDLE;
        endcase
        flash_n = (state_n == S_OVER) | ((state_n == S_MISS) & (flash ^ flash_tog));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            start_q      <= 1'b0;
            frame_cnt    <= '0;
            hit_cnt      <= '0;
            flash_cnt    <= '0;
            level        <= '0;
            lives        <= LIVES_W'(LIVES_INIT);
            flash        <= 1'b0;
            engine_reset <= 1'b1;
            engine_run   <= 1'b0;
        end else begin
            state_q      <= state_n;
            start_q      <= start_btn;
            frame_cnt    <= frame_n;
            hit_cnt      <= hit_n;
            flash_cnt    <= flash_cnt_n;
            level        <= level_n;
            lives        <= lives_n;
            flash        <= flash_n;
            engine_reset <= (state_n == S_IDLE) | (state_n == S_SERVE);
            engine_run   <= (state_n == S_PLAY);
        end
    end

    assign game_state = state_q;

    bcd_score_counter u_score (
        .clk   (clk),
        .reset (reset),
        .clear (score_clear),
        .inc   (score_inc),
        .bcd   (score_bcd)
    );

endmodule
